// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL reset controller: state encodings and
// default timing constants for a 50 MHz reference clock.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } pll_state_t;

    localparam int unsigned REF_CLK_HZ       = 50_000_000;
    localparam int unsigned DEF_RST_HOLD     = 100;
    localparam int unsigned DEF_LOCK_TIMEOUT = REF_CLK_HZ / 100;
    localparam int unsigned DEF_LOCK_STABLE  = 1024;
    localparam int unsigned DEF_LOSS_FILTER  = 4;
    localparam int unsigned DEF_MAX_RETRY    = 3;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a qualified lock
// with timeout and bounded retries, and holds downstream logic in reset.
module pll_rst_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD     = DEF_RST_HOLD,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int unsigned LOSS_FILTER  = DEF_LOSS_FILTER,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock_i,
    input  logic       restart_i,
    output logic       pll_rst_o,
    output logic       sys_rst_o,
    output logic       pll_ready_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o,
    output logic [2:0] state_o
);

    localparam int unsigned CNT_MAX = max3(RST_HOLD, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int CNT_W  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FILT_W = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [FILT_W-1:0] FILT_LAST    = FILT_W'(LOSS_FILTER - 1);
    localparam logic [1:0]        RETRY_LIMIT  = 2'(MAX_RETRY);

    pll_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [FILT_W-1:0] filt, filt_next;
    logic [1:0]        retry, retry_next;
    logic [7:0]        loss, loss_next;
    logic              lock_s;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock_i),
        .q   (lock_s)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        filt_next  = filt;
        retry_next = retry;
        loss_next  = loss;

        if (restart_i) begin
            state_next = ST_RESET_HOLD;
            cnt_next   = '0;
            filt_next  = '0;
            retry_next = '0;
        end else begin
            unique case (state)
                ST_RESET_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                // Lock wins over a timeout landing on the same cycle.
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_next = ST_STABLE;
                        cnt_next   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_next = retry + 2'd1;
                        cnt_next   = '0;
                        state_next = (retry + 2'd1 == RETRY_LIMIT) ? ST_FAIL : ST_RESET_HOLD;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                        filt_next  = '0;
                        retry_next = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (lock_s) begin
                        filt_next = '0;
                    end else if (filt == FILT_LAST) begin
                        state_next = ST_RESET_HOLD;
                        cnt_next   = '0;
                        filt_next  = '0;
                        loss_next  = (loss == 8'hFF) ? loss : loss + 8'd1;
                    end else begin
                        filt_next = filt + 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_next = ST_FAIL;
                end
                default: begin
                    state_next = ST_RESET_HOLD;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RESET_HOLD;
            cnt         <= '0;
            filt        <= '0;
            retry       <= '0;
            loss        <= '0;
            pll_rst_o   <= 1'b1;
            sys_rst_o   <= 1'b1;
            pll_ready_o <= 1'b0;
            fail_o      <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            filt        <= filt_next;
            retry       <= retry_next;
            loss        <= loss_next;
            pll_rst_o   <= (state_next == ST_RESET_HOLD) || (state_next == ST_FAIL);
            sys_rst_o   <= (state_next != ST_RUN);
            pll_ready_o <= (state_next == ST_RUN);
            fail_o      <= (state_next == ST_FAIL);
        end
    end

    assign retry_cnt_o = retry;
    assign loss_cnt_o  = loss;
    assign state_o     = state;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scoreboard bench for pll_rst_ctrl: stimulus queues hand-computed expectations
// keyed by cycle number; a negedge monitor pops and compares them.
module tb_pll_rst_ctrl;
    import pll_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock_i;
    logic       restart_i;
    logic       pll_rst_o;
    logic       sys_rst_o;
    logic       pll_ready_o;
    logic       fail_o;
    logic [1:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;
    logic [2:0] state_o;

    typedef struct packed {
        int         cycle;
        logic [2:0] st;
        logic [1:0] retry;
        logic [7:0] loss;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    tests_run = 0;
    int    tests_failed = 0;

    pll_rst_ctrl #(
        .RST_HOLD     (4),
        .LOCK_TIMEOUT (20),
        .LOCK_STABLE  (8),
        .LOSS_FILTER  (2),
        .MAX_RETRY    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock_i  (pll_lock_i),
        .restart_i   (restart_i),
        .pll_rst_o   (pll_rst_o),
        .sys_rst_o   (sys_rst_o),
        .pll_ready_o (pll_ready_o),
        .fail_o      (fail_o),
        .retry_cnt_o (retry_cnt_o),
        .loss_cnt_o  (loss_cnt_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectAt(input int off, input pll_state_t st, input logic [1:0] retry,
                            input logic [7:0] loss, input string name);
        exp_t e;
        e.cycle = cyc + off;
        e.st    = st;
        e.retry = retry;
        e.loss  = loss;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        logic w_prst, w_srst, w_rdy, w_fail;
        w_prst = (e.st == ST_RESET_HOLD) || (e.st == ST_FAIL);
        w_srst = (e.st != ST_RUN);
        w_rdy  = (e.st == ST_RUN);
        w_fail = (e.st == ST_FAIL);
        tests_run++;
        if (state_o !== e.st || pll_rst_o !== w_prst || sys_rst_o !== w_srst ||
            pll_ready_o !== w_rdy || fail_o !== w_fail ||
            retry_cnt_o !== e.retry || loss_cnt_o !== e.loss) begin
            tests_failed++;
            $display("[TB] FAIL %s @cycle %0d: got state=%0d pll_rst=%0b sys_rst=%0b ready=%0b fail=%0b retry=%0d loss=%0d, want state=%0d pll_rst=%0b sys_rst=%0b ready=%0b fail=%0b retry=%0d loss=%0d",
                     name, cyc, state_o, pll_rst_o, sys_rst_o, pll_ready_o, fail_o, retry_cnt_o,
                     loss_cnt_o, e.st, w_prst, w_srst, w_rdy, w_fail, e.retry, e.loss);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string nm;
        while (exp_q.size() > 0 && exp_q[0].cycle <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.cycle < cyc) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL %s: sample for cycle %0d missed, now at cycle %0d", nm, e.cycle, cyc);
            end else begin
                checkOutput(e, nm);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        pll_lock_i = 1'b0;
        restart_i  = 1'b0;
        applyStimulus(3);

        // Nominal bring-up
        expectAt(0, ST_RESET_HOLD, 2'd0, 8'd0, "reset_state");
        rst = 1'b0;
        expectAt(3, ST_RESET_HOLD, 2'd0, 8'd0, "hold_last");
        expectAt(4, ST_WAIT_LOCK, 2'd0, 8'd0, "hold_end");
        applyStimulus(9);
        pll_lock_i = 1'b1;
        expectAt(2, ST_WAIT_LOCK, 2'd0, 8'd0, "lock_sync_delay");
        expectAt(3, ST_STABLE, 2'd0, 8'd0, "stable_entry");
        expectAt(10, ST_STABLE, 2'd0, 8'd0, "stable_last");
        expectAt(11, ST_RUN, 2'd0, 8'd0, "run_entry");
        applyStimulus(11);

        // Loss filter in RUN
        pll_lock_i = 1'b0;
        expectAt(3, ST_RUN, 2'd0, 8'd0, "run_glitch_hold");
        expectAt(5, ST_RUN, 2'd0, 8'd0, "run_glitch_after");
        applyStimulus(1);
        pll_lock_i = 1'b1;
        applyStimulus(5);
        pll_lock_i = 1'b0;
        expectAt(3, ST_RUN, 2'd0, 8'd0, "loss_first_low");
        expectAt(4, ST_RESET_HOLD, 2'd0, 8'd1, "loss_to_hold");
        expectAt(8, ST_WAIT_LOCK, 2'd0, 8'd1, "loss_wait");
        expectAt(9, ST_STABLE, 2'd0, 8'd1, "loss_stable");
        expectAt(17, ST_RUN, 2'd0, 8'd1, "loss_rerun");
        applyStimulus(2);
        pll_lock_i = 1'b1;
        applyStimulus(15);

        // Restart from RUN, then a one-cycle lock glitch in STABLE
        restart_i = 1'b1;
        expectAt(1, ST_RESET_HOLD, 2'd0, 8'd1, "restart_run");
        expectAt(5, ST_WAIT_LOCK, 2'd0, 8'd1, "restart_wait");
        expectAt(6, ST_STABLE, 2'd0, 8'd1, "glitch_stable_in");
        expectAt(10, ST_STABLE, 2'd0, 8'd1, "glitch_stable_5");
        expectAt(11, ST_WAIT_LOCK, 2'd0, 8'd1, "glitch_back_wait");
        expectAt(12, ST_STABLE, 2'd0, 8'd1, "glitch_restable");
        expectAt(19, ST_STABLE, 2'd0, 8'd1, "glitch_stable_8");
        expectAt(20, ST_RUN, 2'd0, 8'd1, "glitch_run");
        applyStimulus(1);
        restart_i = 1'b0;
        applyStimulus(7);
        pll_lock_i = 1'b0;
        applyStimulus(1);
        pll_lock_i = 1'b1;
        applyStimulus(12);

        // Timeouts into FAIL
        pll_lock_i = 1'b0;
        expectAt(3, ST_RUN, 2'd0, 8'd1, "to_run_low1");
        expectAt(4, ST_RESET_HOLD, 2'd0, 8'd2, "to_loss");
        expectAt(8, ST_WAIT_LOCK, 2'd0, 8'd2, "to_wait_first");
        expectAt(27, ST_WAIT_LOCK, 2'd0, 8'd2, "to_wait_last");
        expectAt(28, ST_RESET_HOLD, 2'd1, 8'd2, "to_retry1");
        expectAt(31, ST_RESET_HOLD, 2'd1, 8'd2, "to_retry1_hold");
        expectAt(32, ST_WAIT_LOCK, 2'd1, 8'd2, "to_wait2");
        expectAt(51, ST_WAIT_LOCK, 2'd1, 8'd2, "to_wait2_last");
        expectAt(52, ST_FAIL, 2'd2, 8'd2, "fail_entry");
        expectAt(152, ST_FAIL, 2'd2, 8'd2, "fail_hold");
        applyStimulus(152);

        // Restart from FAIL, then restart together with rst
        restart_i = 1'b1;
        expectAt(1, ST_RESET_HOLD, 2'd0, 8'd2, "restart_fail");
        expectAt(5, ST_WAIT_LOCK, 2'd0, 8'd2, "restart_fail_wait");
        applyStimulus(1);
        restart_i = 1'b0;
        applyStimulus(5);
        rst       = 1'b1;
        restart_i = 1'b1;
        expectAt(1, ST_RESET_HOLD, 2'd0, 8'd0, "rst_over_restart");
        expectAt(24, ST_WAIT_LOCK, 2'd0, 8'd0, "edge_wait_last");
        expectAt(25, ST_STABLE, 2'd0, 8'd0, "timeout_vs_lock");
        expectAt(33, ST_RUN, 2'd0, 8'd0, "edge_run");
        applyStimulus(1);
        rst       = 1'b0;
        restart_i = 1'b0;
        applyStimulus(21);
        pll_lock_i = 1'b1;
        applyStimulus(11);

        // Loss counter saturation
        for (int i = 1; i <= 260; i++) begin
            logic [7:0] l;
            l = (i > 255) ? 8'd255 : 8'(i);
            pll_lock_i = 1'b0;
            expectAt(4, ST_RESET_HOLD, 2'd0, l, "loss_sat");
            applyStimulus(2);
            pll_lock_i = 1'b1;
            applyStimulus(15);
        end
        expectAt(1, ST_RUN, 2'd0, 8'd255, "loss_sat_final");
        applyStimulus(3);

        while (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: expectation for cycle %0d never sampled", name_q.pop_front(),
                     exp_q.pop_front().cycle);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pll_rst_ctrl.md
Name: pll_rst_ctrl

Overview:
- Sequences the board PLL: generates its reset pulse, waits for lock with a timeout and bounded retries, and qualifies lock as stable.
- Asserts a synchronous system reset for downstream logic until the PLL is usable.
- Runs on the free-running 50 MHz reference clock that also feeds the PLL input, so it never depends on PLL outputs.
- Sits between the top-level reset and the PLL instance; its ready/reset outputs gate all PLL-clocked domains.

Parameters:
- RST_HOLD, 100, cycles pll_rst_o is held high per reset attempt (>=1)
- LOCK_TIMEOUT, 500000, cycles allowed in WAIT_LOCK before a retry (10 ms at 50 MHz)
- LOCK_STABLE, 1024, consecutive synchronized-lock-high cycles required before RUN
- LOSS_FILTER, 4, consecutive synchronized-lock-low cycles in RUN treated as lock loss
- MAX_RETRY, 3, lock timeouts tolerated before FAIL (>=1)

Ports:
- clk  in  1  reference clock, 50 MHz
- rst  in  1  synchronous active-high reset
- pll_lock_i  in  1  raw PLL lock, asynchronous to clk
- restart_i  in  1  single-cycle request to re-run the full sequence
- pll_rst_o  out  1  reset to PLL, active-high
- sys_rst_o  out  1  downstream synchronous reset, active-high
- pll_ready_o  out  1  high only in RUN
- fail_o  out  1  high only in FAIL
- retry_cnt_o  out  2  timeouts in the current attempt series
- loss_cnt_o  out  8  lock-loss events seen in RUN, saturating at 255
- state_o  out  3  current state encoding, for debug

Behaviour:
- Lock input: pll_lock_i passes through a 2-flop synchronizer to give lock_s, adding 2 cycles of latency. All decisions use lock_s only.
- Registered outputs: every output updates on the same edge as the state register and decodes the new state.
- Reset (rst=1): state=RESET_HOLD, cnt=0, pll_rst_o=1, sys_rst_o=1, pll_ready_o=0, fail_o=0, retry_cnt_o=0, loss_cnt_o=0.
- RESET_HOLD: pll_rst_o=1. After exactly RST_HOLD cycles in this state, go to WAIT_LOCK with cnt=0.
- WAIT_LOCK: pll_rst_o=0.
  - lock_s=1: go to STABLE with cnt=0.
  - Otherwise, when cnt==LOCK_TIMEOUT-1: retry_cnt+1. If the new value equals MAX_RETRY, go to FAIL; else go to RESET_HOLD.
- STABLE:
  - lock_s=0 on any cycle: return to WAIT_LOCK with cnt=0 and no retry increment.
  - After LOCK_STABLE consecutive high cycles: go to RUN and clear retry_cnt.
- RUN: pll_ready_o=1, sys_rst_o=0.
  - Each cycle lock_s=0 increments the filter count; each cycle lock_s=1 clears it.
  - When the filter count reaches LOSS_FILTER: loss_cnt+1 (saturating), go to RESET_HOLD.
- FAIL: pll_rst_o=1, fail_o=1, sys_rst_o=1. Remain here until restart_i or rst.
- sys_rst_o=1 and pll_ready_o=0 in every state except RUN.
- restart_i=1 in any state: next state RESET_HOLD, cnt=0, retry_cnt=0. loss_cnt is preserved.
- Simultaneous events:
  - rst has priority over restart_i.
  - restart_i has priority over all state-internal transitions.
  - A timeout and lock_s rising on the same cycle count as lock (go to STABLE).
- Counter width: a single shared counter sized by $clog2 of the largest of RST_HOLD, LOCK_TIMEOUT, LOCK_STABLE. It never wraps, because each state exits at its terminal count.
- State encoding (state_o): RESET_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Decomposition:
- Shared package pll_ctrl_pkg holds the state enum/encodings and default timing constants derived from a 50 MHz clock.
- One sub-module, sync_2ff: a generic single-bit two-flop synchronizer with a reset value parameter, used for pll_lock_i.

Test Plan:
Bench settings: RST_HOLD=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, LOSS_FILTER=2, MAX_RETRY=2.
1. Nominal bring-up: release rst, raise pll_lock_i 5 cycles after pll_rst_o falls -> pll_rst_o high exactly 4 cycles; STABLE entered 2 cycles after the lock edge; pll_ready_o=1 and sys_rst_o=0 after 8 more cycles; retry_cnt_o=0.
2. Lock glitch in STABLE: drop lock for 1 cycle after 5 stable cycles -> return to WAIT_LOCK, retry_cnt_o unchanged; a full 8-cycle stable run then reaches RUN.
3. Timeout then fail: hold lock low -> after 20 cycles in WAIT_LOCK, retry_cnt_o=1 and a new 4-cycle pll_rst_o pulse; after the second timeout, fail_o=1, pll_rst_o=1, state_o=4. Holding 100 cycles stays in FAIL.
4. Loss in RUN: from RUN, lock low 1 cycle -> stays in RUN. Lock low 2 consecutive cycles (after sync) -> loss_cnt_o=1, RESET_HOLD, sys_rst_o=1 on the same edge as pll_ready_o falls.
5. Restart and priority: from FAIL, pulse restart_i -> RESET_HOLD next cycle, retry_cnt_o=0, loss_cnt_o preserved. restart_i together with rst -> reset values, loss_cnt_o=0.
6. Saturation: force 260 loss events -> loss_cnt_o holds at 255.
